enc_16_4_seq: RTL and testbench

- Sequential 16-to-4 encoder, the inverse of the team's 4-to-16 decoder.
- Captures a 16-bit request vector and emits the 4-bit index of every set bit, one index per handshake, in priority order.
- Sits between the request/flag collectors and any downstream consumer that takes one encoded index at a time (e.g. an index → dec_4_16 path).

---
 rtl/enc_16_4_seq.sv | 136 +++++++++++++
 tb/tb_enc_16_4_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_16_4_seq.sv
// Sequential 16-to-4 encoder: captures a request vector and hands out one set-bit index per handshake.
// Optional population-count output is enabled by defining ENC_16_4_CNT_EN.
module enc_16_4_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out,
    output logic        out_last,
    output logic        zero
`ifdef ENC_16_4_CNT_EN
    ,output logic [4:0] cnt
`endif
);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [15:0] pending_q, pending_d;
    logic [3:0]  out_q, out_d;
    logic        outLast_q, outLast_d;
    logic        outValid_q, outValid_d;
    logic        inReady_q, inReady_d;
    logic        zero_q, zero_d;
`ifdef ENC_16_4_CNT_EN
    logic [4:0]  cnt_q, cnt_d;
`endif

    // Index of the bit that wins the scan priority; an empty vector encodes as 0.
    function automatic logic [3:0] encode(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        if (LSB_FIRST) begin
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) idx = 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic singleBit(input logic [15:0] v);
        return (v != 16'h0000) && ((v & (v - 16'd1)) == 16'h0000);
    endfunction

`ifdef ENC_16_4_CNT_EN
    function automatic logic [4:0] popCount(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction
`endif

    // Outputs are precomputed from the next pending vector so that every output is a flop.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = 1'b0;
`ifdef ENC_16_4_CNT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ENC_16_4_CNT_EN
                    cnt_d = popCount(in);
`endif
                    if (in != 16'h0000) begin
                        pending_d = in;
                        state_d   = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pending_d = pending_q & ~(16'd1 << out_q);
                    if (outLast_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        out_d      = encode(pending_d);
        outLast_d  = singleBit(pending_d);
        outValid_d = (state_d == SCAN);
        inReady_d  = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= 16'h0000;
            out_q      <= 4'd0;
            outLast_q  <= 1'b0;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
            zero_q     <= 1'b0;
`ifdef ENC_16_4_CNT_EN
            cnt_q      <= 5'd0;
`endif
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            out_q      <= out_d;
            outLast_q  <= outLast_d;
            outValid_q <= outValid_d;
            inReady_q  <= inReady_d;
            zero_q     <= zero_d;
`ifdef ENC_16_4_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign in_ready  = inReady_q;
    assign out_valid = outValid_q;
    assign out       = out_q;
    assign out_last  = outLast_q;
    assign zero      = zero_q;
`ifdef ENC_16_4_CNT_EN
    assign cnt       = cnt_q;
`endif

endmodule

// File: tb/tb_enc_16_4_seq.sv
// Scoreboard bench for enc_16_4_seq: one LSB-first and one MSB-first instance share the same stimulus.
module tb_enc_16_4_seq;

    typedef struct packed {
        logic [3:0] idx;
        logic       last;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [15:0] vecIn;
    logic        outReady;

    logic        inReadyL, outValidL, outLastL, zeroL;
    logic [3:0]  outL;
    logic        inReadyM, outValidM, outLastM, zeroM;
    logic [3:0]  outM;
`ifdef ENC_16_4_CNT_EN
    logic [4:0]  cntL, cntM;
`endif

    exp_t expL[$];
    exp_t expM[$];

    int testCount = 0;
    int failCount = 0;

    enc_16_4_seq #(.LSB_FIRST(1'b1)) dutL (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReadyL), .in(vecIn),
        .out_valid(outValidL), .out_ready(outReady), .out(outL),
        .out_last(outLastL), .zero(zeroL)
`ifdef ENC_16_4_CNT_EN
        , .cnt(cntL)
`endif
    );

    enc_16_4_seq #(.LSB_FIRST(1'b0)) dutM (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReadyM), .in(vecIn),
        .out_valid(outValidM), .out_ready(outReady), .out(outM),
        .out_last(outLastM), .zero(zeroM)
`ifdef ENC_16_4_CNT_EN
        , .cnt(cntM)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushExp(input bit lsb, input int idx, input bit last);
        exp_t e;
        e.idx  = 4'(idx);
        e.last = last;
        if (lsb) expL.push_back(e);
        else     expM.push_back(e);
    endtask

    task automatic applyStimulus(input logic [15:0] v);
        inValid = 1'b1;
        vecIn   = v;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        vecIn   = 16'h0000;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expL.size() != 0 || expM.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expL.size() != 0 || expM.size() != 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL drainTimeout: got %0d/%0d pending, expected 0", expL.size(), expM.size());
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_inReadyL"}, int'(inReadyL), 1);
        checkOutput({tag, "_inReadyM"}, int'(inReadyM), 1);
        checkOutput({tag, "_outValidL"}, int'(outValidL), 0);
        checkOutput({tag, "_outValidM"}, int'(outValidM), 0);
    endtask

    // Monitor: every handshake seen just before a rising edge consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && outReady) begin
            if (outValidL) begin
                if (expL.size() == 0) begin
                    checkOutput("lsbUnexpected", int'(outL), -1);
                end else begin
                    exp_t e;
                    e = expL.pop_front();
                    checkOutput("lsbIdx", int'(outL), int'(e.idx));
                    checkOutput("lsbLast", int'(outLastL), int'(e.last));
                end
            end
            if (outValidM) begin
                if (expM.size() == 0) begin
                    checkOutput("msbUnexpected", int'(outM), -1);
                end else begin
                    exp_t e;
                    e = expM.pop_front();
                    checkOutput("msbIdx", int'(outM), int'(e.idx));
                    checkOutput("msbLast", int'(outLastM), int'(e.last));
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        vecIn    = 16'h0000;
        outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkIdle("reset");
        checkOutput("reset_outL", int'(outL), 0);
        checkOutput("reset_outLastL", int'(outLastL), 0);
        checkOutput("reset_zeroL", int'(zeroL), 0);
        checkOutput("reset_zeroM", int'(zeroM), 0);
`ifdef ENC_16_4_CNT_EN
        checkOutput("reset_cnt", int'(cntL), 0);
`endif
        rst = 1'b0;

        // All-zero vector: one zero pulse, nothing emitted.
        applyStimulus(16'h0000);
        checkOutput("zeroPulseL", int'(zeroL), 1);
        checkOutput("zeroPulseM", int'(zeroM), 1);
        checkIdle("zeroCap");
        @(posedge clk);
        #1;
        checkOutput("zeroEndL", int'(zeroL), 0);
        checkIdle("zeroAfter");

        // 16'h8421 streamed with a permanently ready consumer.
        outReady = 1'b1;
        pushExp(1, 0, 0); pushExp(1, 5, 0); pushExp(1, 10, 0); pushExp(1, 15, 1);
        pushExp(0, 15, 0); pushExp(0, 10, 0); pushExp(0, 5, 0); pushExp(0, 0, 1);
        applyStimulus(16'h8421);
        checkOutput("cap8421_inReady", int'(inReadyL), 0);
        waitDrain();
        checkIdle("done8421");
`ifdef ENC_16_4_CNT_EN
        checkOutput("cnt8421", int'(cntL), 4);
`endif

        // 16'h0006 with the consumer stalled for three cycles; a capture attempt mid-scan is ignored.
        outReady = 1'b0;
        pushExp(1, 1, 0); pushExp(1, 2, 1);
        pushExp(0, 2, 0); pushExp(0, 1, 1);
        applyStimulus(16'h0006);
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_outL", int'(outL), 1);
            checkOutput("stall_outM", int'(outM), 2);
            checkOutput("stall_validL", int'(outValidL), 1);
            checkOutput("stall_lastL", int'(outLastL), 0);
            checkOutput("stall_inReady", int'(inReadyL), 0);
            inValid = (k == 0);
            vecIn   = 16'hFFFF;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        vecIn   = 16'h0000;
        checkOutput("stall4_outL", int'(outL), 1);
        checkOutput("stall4_outM", int'(outM), 2);
        outReady = 1'b1;
        waitDrain();
        checkIdle("done0006");
`ifdef ENC_16_4_CNT_EN
        checkOutput("cnt0006", int'(cntL), 2);
`endif

        // 16'hFFFF interrupted by reset after five transfers.
        for (int i = 0; i < 16; i++) begin
            pushExp(1, i, i == 15);
            pushExp(0, 15 - i, i == 15);
        end
        applyStimulus(16'hFFFF);
`ifdef ENC_16_4_CNT_EN
        checkOutput("cntFFFF", int'(cntL), 16);
`endif
        repeat (5) @(posedge clk);
        #1;
        outReady = 1'b0;
        checkOutput("mid_outL", int'(outL), 5);
        checkOutput("mid_outM", int'(outM), 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdle("midReset");
        checkOutput("midReset_outL", int'(outL), 0);
        checkOutput("midReset_outM", int'(outM), 0);
        checkOutput("midReset_lastL", int'(outLastL), 0);
`ifdef ENC_16_4_CNT_EN
        checkOutput("midReset_cnt", int'(cntL), 0);
`endif
        expL.delete();
        expM.delete();

        // Fresh single-bit capture after the reset.
        outReady = 1'b1;
        pushExp(1, 4, 1);
        pushExp(0, 4, 1);
        applyStimulus(16'h0010);
        waitDrain();
        checkIdle("done0010");

        // Single-bit boundaries at both ends of the vector.
        pushExp(1, 15, 1);
        pushExp(0, 15, 1);
        applyStimulus(16'h8000);
        waitDrain();
        pushExp(1, 0, 1);
        pushExp(0, 0, 1);
        applyStimulus(16'h0001);
        waitDrain();
        checkIdle("done0001");

        // A zero capture clears the population count.
        applyStimulus(16'h0000);
        checkOutput("zero2PulseL", int'(zeroL), 1);
`ifdef ENC_16_4_CNT_EN
        checkOutput("cntZero", int'(cntL), 0);
`endif

        checkOutput("queueL_empty", expL.size(), 0);
        checkOutput("queueM_empty", expM.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
